intr_source: RTL and testbench
==============================

INTR_SOURCE -- requirements
Module: intr_source

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the event-counter and threshold width.
REQ-002 The module SHALL have parameter OVF_W, default 8, giving the overflow-counter width.
REQ-003 The module SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-004 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-006 Port en SHALL be an input, 1 bit wide: block enable.
REQ-007 Port thresh SHALL be an input, CNT_W bits wide: number of events per interrupt; a value of 0 is treated as 1.
REQ-008 Port event_in SHALL be an input, 1 bit wide: one event per cycle when high.
REQ-009 Port ack SHALL be an input, 1 bit wide: interrupt acknowledge from the consumer.
REQ-010 Port intr SHALL be an output, 1 bit wide: level interrupt, registered.
REQ-011 Port evt_cnt SHALL be an output, CNT_W bits wide: current event count, registered.
REQ-012 Port ovf_cnt SHALL be an output, OVF_W bits wide: count of threshold hits that occurred while an interrupt was already pending, registered.

Function
REQ-013 The FSM SHALL have three states: IDLE, COUNT and PEND.
REQ-014 In IDLE: intr=0 and evt_cnt=0; the FSM SHALL go to COUNT on the cycle after en=1 is sampled.
REQ-015 In COUNT or PEND with event_in=1, evt_cnt SHALL increment by 1 on each clock.
REQ-016 A threshold hit ("hit") SHALL be event_in=1 and evt_cnt+1 >= max(thresh,1); on a hit, evt_cnt SHALL load 0 instead of incrementing.
REQ-017 On a hit in COUNT, the FSM SHALL go to PEND and intr SHALL be 1 from the next cycle, so intr asserts 1 cycle after the last event.
REQ-018 In PEND, intr SHALL stay 1 until ack is sampled; ack=1 SHALL give intr=0 and state COUNT on the next cycle, and ovf_cnt SHALL load 0.
REQ-019 A hit in PEND without ack SHALL increment ovf_cnt, saturating at 2^OVF_W-1, with no wrap.
REQ-020 A hit and ack in the same PEND cycle SHALL keep the FSM in PEND with intr held at 1 (new interrupt), and ovf_cnt SHALL load 0.
REQ-021 ack sampled in IDLE or COUNT SHALL be ignored.
REQ-022 en=0 sampled in COUNT or PEND SHALL force IDLE on the next cycle: intr=0, evt_cnt=0, ovf_cnt held; event_in on that cycle SHALL be ignored.
REQ-023 If thresh changes mid-count, it SHALL take effect on the next compare; because the hit uses >=, a lowered threshold SHALL trigger a hit on the next event.
REQ-024 evt_cnt at all-ones with event_in=1 SHALL always produce a hit, so evt_cnt never wraps.

Reset
REQ-025 rst=1 SHALL give, on the next edge: state=IDLE, intr=0, evt_cnt=0, ovf_cnt=0; rst SHALL have priority over en, event_in and ack.
REQ-026 Reset asserted in PEND SHALL drop intr the following cycle, with no pending interrupt retained.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, COUNT, PEND) and the default CNT_W and OVF_W constants.
REQ-028 The block SHALL be a single module with no sub-modules; the saturating counter is inline logic.

Verification
REQ-029 Scenario: thresh=3, en=1, event_in pulsed 3 times -> intr=1 one cycle after the 3rd event, evt_cnt=0, ovf_cnt=0.
REQ-030 Scenario: PEND with thresh=2, 6 further events without ack -> ovf_cnt=3; then ack -> next cycle intr=0, ovf_cnt=0, state COUNT.
REQ-031 Scenario: thresh=1, event_in held high and ack pulsed while pending -> intr stays 1 continuously, ovf_cnt=0 after the ack cycle.
REQ-032 Scenario: OVF_W=2, 10 hits while pending -> ovf_cnt saturates at 3.
REQ-033 Scenario: thresh=0, a single event -> treated as thresh=1, intr asserts.
REQ-034 Scenario: rst=1 or en=0 while in PEND with evt_cnt=5 -> next cycle intr=0, evt_cnt=0; ovf_cnt=0 after rst, held after en=0.

Source files
------------

// File: rtl/intr_source_pkg.sv
// Shared definitions for the threshold interrupt source: FSM state encoding and
// default counter widths.
package intr_source_pkg;

  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_OVF_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PEND  = 2'd2
  } intr_state_e;

endpackage

// File: rtl/intr_source.sv
// Counts events and raises a level interrupt every max(thresh,1) events; hits
// while an interrupt is still pending are tallied in a saturating overflow counter.
module intr_source
  import intr_source_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned OVF_W = DEF_OVF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] thresh,
  input  logic             event_in,
  input  logic             ack,
  output logic             intr,
  output logic [CNT_W-1:0] evt_cnt,
  output logic [OVF_W-1:0] ovf_cnt
);

  logic [1:0]       state_q, state_d;
  logic             intr_q, intr_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic [CNT_W-1:0] thresh_eff;
  logic [CNT_W:0]   cnt_inc;
  logic             hit;

  // One extra bit on the compare so an all-ones count always hits instead of wrapping.
  always_comb begin
    thresh_eff = (thresh == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : thresh;
    cnt_inc    = {1'b0, evt_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    hit        = event_in && (cnt_inc >= {1'b0, thresh_eff});
  end

  always_comb begin
    state_d   = state_q;
    intr_d    = intr_q;
    evt_cnt_d = evt_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    case (state_q)
      COUNT, PEND: begin
        if (!en) begin
          state_d   = IDLE;
          intr_d    = 1'b0;
          evt_cnt_d = '0;
        end else begin
          if (hit) begin
            evt_cnt_d = '0;
          end else if (event_in) begin
            evt_cnt_d = evt_cnt_q + 1'b1;
          end
          if (state_q == COUNT) begin
            if (hit) begin
              state_d = PEND;
              intr_d  = 1'b1;
            end
          end else if (ack) begin
            // A hit coinciding with ack re-arms a fresh interrupt.
            ovf_cnt_d = '0;
            state_d   = hit ? PEND : COUNT;
            intr_d    = hit;
          end else if (hit && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        intr_d    = 1'b0;
        evt_cnt_d = '0;
        state_d   = en ? COUNT : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      intr_q    <= 1'b0;
      evt_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      intr_q    <= intr_d;
      evt_cnt_q <= evt_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign intr    = intr_q;
  assign evt_cnt = evt_cnt_q;
  assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_intr_source.sv
// Directed scenarios plus random traffic for intr_source, checked against an
// integer-level behavioural model of the interrupt rules.
module tb_intr_source;

  localparam int CW = 4;
  localparam int OW = 2;
  localparam int OVF_MAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, event_in, ack;
  logic [CW-1:0] thresh;
  logic          intr;
  logic [CW-1:0] evt_cnt;
  logic [OW-1:0] ovf_cnt;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit m_active, m_pend;
  int m_cnt, m_ovf;

  intr_source #(.CNT_W(CW), .OVF_W(OW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .thresh   (thresh),
    .event_in (event_in),
    .ack      (ack),
    .intr     (intr),
    .evt_cnt  (evt_cnt),
    .ovf_cnt  (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input int t, input bit ev, input bit a);
    int  eff;
    bit  h;
    eff = (t == 0) ? 1 : t;
    if (r) begin
      m_active = 0; m_pend = 0; m_cnt = 0; m_ovf = 0;
    end else if (!m_active) begin
      m_active = e; m_pend = 0; m_cnt = 0;
    end else if (!e) begin
      m_active = 0; m_pend = 0; m_cnt = 0;
    end else begin
      h = ev && (m_cnt + 1 >= eff);
      m_cnt = h ? 0 : m_cnt + int'(ev);
      if (m_pend) begin
        if (a) begin
          m_ovf  = 0;
          m_pend = h;
        end else if (h && m_ovf < OVF_MAX) begin
          m_ovf++;
        end
      end else if (h) begin
        m_pend = 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input int t, input bit ev, input bit a);
    rst = r; en = e; thresh = CW'(t); event_in = ev; ack = a;
    @(posedge clk);
    model_step(r, e, t, ev, a);
    #1;
    check("intr", int'(intr), int'(m_pend));
    check("evt_cnt", int'(evt_cnt), m_cnt);
    check("ovf_cnt", int'(ovf_cnt), m_ovf);
  endtask

  initial begin
    m_active = 0; m_pend = 0; m_cnt = 0; m_ovf = 0;
    rst = 1; en = 0; thresh = '0; event_in = 0; ack = 0;
    #1;
    cyc(1, 1, 3, 1, 1);
    cyc(1, 1, 3, 1, 0);
    check("reset_intr", int'(intr), 0);
    check("reset_ovf", int'(ovf_cnt), 0);

    // Three events at thresh=3
    cyc(0, 1, 3, 0, 0);
    cyc(0, 1, 3, 1, 0);
    cyc(0, 1, 3, 1, 0);
    check("s3_not_yet", int'(intr), 0);
    cyc(0, 1, 3, 1, 0);
    check("s3_intr", int'(intr), 1);
    check("s3_evt", int'(evt_cnt), 0);
    check("s3_ovf", int'(ovf_cnt), 0);

    // Six more events at thresh=2 while pending, then ack
    for (int i = 0; i < 6; i++) cyc(0, 1, 2, 1, 0);
    check("ovf3", int'(ovf_cnt), 3);
    check("ovf3_intr", int'(intr), 1);
    cyc(0, 1, 2, 0, 1);
    check("ack_intr", int'(intr), 0);
    check("ack_ovf", int'(ovf_cnt), 0);

    // thresh=1 with event held high, ack mid-stream
    cyc(0, 1, 1, 1, 0);
    check("hold_intr0", int'(intr), 1);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 1);
    check("hold_intr_ack", int'(intr), 1);
    check("hold_ovf_ack", int'(ovf_cnt), 0);

    // Ten hits while pending saturate the 2-bit overflow counter
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1, 0);
    check("sat_ovf", int'(ovf_cnt), 3);
    cyc(0, 1, 1, 0, 1);
    check("sat_ack_intr", int'(intr), 0);

    // thresh=0 acts as 1
    cyc(0, 1, 0, 1, 0);
    check("t0_intr", int'(intr), 1);

    // evt_cnt=5 in PEND with ovf=2, then en=0
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8, 1, 0);
    check("pre_dis_evt", int'(evt_cnt), 5);
    check("pre_dis_ovf", int'(ovf_cnt), 2);
    cyc(0, 0, 8, 1, 0);
    check("dis_intr", int'(intr), 0);
    check("dis_evt", int'(evt_cnt), 0);
    check("dis_ovf", int'(ovf_cnt), 2);

    // Same setup, then reset
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8, 1, 0);
    check("pre_rst_evt", int'(evt_cnt), 5);
    cyc(1, 1, 8, 1, 0);
    check("rst_intr", int'(intr), 0);
    check("rst_evt", int'(evt_cnt), 0);
    check("rst_ovf", int'(ovf_cnt), 0);

    // Random traffic
    begin
      int t;
      t = 3;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) t = $urandom_range(0, 6);
        cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) != 0, t,
            $urandom_range(0, 9) < 6, $urandom_range(0, 4) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
